spi_instr_loader: RTL and testbench

SPI slave that receives instruction words from an external host and writes them into the PIO core's instruction register file. It is the writer side of the instruction_regfile write port, driving write_addr, instr_in and write_en. It replaces the tied-off write path in pio_core. SPI pins are asynchronous to clk and are oversampled and synchronized internally.

---
 rtl/spi_instr_loader.sv | 178 +++++++++++++++++
 tb/tb_spi_instr_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_instr_loader.sv
// SPI mode-0 slave that loads instruction words into the PIO instruction register file.
// All SPI pins are oversampled on clk; edges are detected on the synchronized copies.
module spi_instr_loader #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [INSTR_W-1:0] instr_in,
  output logic               write_en,
  output logic               busy,
  output logic               frame_abort,
  output logic [7:0]         write_count
);

  localparam int unsigned MaxBits = (INSTR_W > 8) ? INSTR_W : 8;
  localparam int unsigned CntW    = $clog2(MaxBits + 1);
  localparam logic [CntW-1:0] LastHdrBit  = CntW'(7);
  localparam logic [CntW-1:0] LastWordBit = CntW'(INSTR_W - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StData, StIgnore} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [INSTR_W-2:0]     shift_q, shift_d;
  logic [7:0]             miso_sh_q, miso_sh_d;
  logic [ADDR_W-1:0]      addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0]      write_addr_q, write_addr_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  logic                   write_en_q, write_en_d;
  logic                   abort_q, abort_d;
  logic [7:0]             count_q, count_d;

  logic               sclk_s, cs_s, mosi_s;
  logic               sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [INSTR_W-1:0] shifted;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  // Shift register is cleared outside a frame, so a start coinciding with a rise sees zeros.
  assign shifted   = {shift_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    miso_sh_d    = miso_sh_q;
    addr_cnt_d   = addr_cnt_q;
    write_addr_d = write_addr_q;
    instr_d      = instr_q;
    count_d      = count_q;
    write_en_d   = 1'b0;
    abort_d      = 1'b0;

    if (cs_rise) begin
      if (state_q != StIdle && bit_cnt_q != '0) abort_d = 1'b1;
      state_d   = StIdle;
      bit_cnt_d = '0;
      shift_d   = '0;
      miso_sh_d = '0;
    end else begin
      if (cs_fall) begin
        state_d   = StHeader;
        bit_cnt_d = '0;
        shift_d   = '0;
        miso_sh_d = count_q;
      end else if (sclk_fall && state_q == StHeader) begin
        miso_sh_d = {miso_sh_q[6:0], 1'b0};
      end

      // state_d already reflects a same-cycle frame start, so that edge is header bit 0.
      if (sclk_rise) begin
        unique case (state_d)
          StIdle: ;
          StHeader: begin
            if (bit_cnt_d == LastHdrBit) begin
              bit_cnt_d  = '0;
              shift_d    = '0;
              addr_cnt_d = shifted[ADDR_W-1:0];
              state_d    = shifted[7] ? StData : StIgnore;
            end else begin
              bit_cnt_d = bit_cnt_d + 1'b1;
              shift_d   = shifted[INSTR_W-2:0];
            end
          end
          StData: begin
            if (bit_cnt_d == LastWordBit) begin
              bit_cnt_d    = '0;
              shift_d      = '0;
              write_en_d   = 1'b1;
              write_addr_d = addr_cnt_q;
              instr_d      = shifted;
              addr_cnt_d   = addr_cnt_q + 1'b1;
              count_d      = count_q + 8'd1;
            end else begin
              bit_cnt_d = bit_cnt_d + 1'b1;
              shift_d   = shifted[INSTR_W-2:0];
            end
          end
          StIgnore: begin
            // Track word boundaries so a clean end of frame is not flagged as an abort.
            bit_cnt_d = (bit_cnt_d == LastWordBit) ? '0 : bit_cnt_d + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      miso_sh_q    <= '0;
      addr_cnt_q   <= '0;
      write_addr_q <= '0;
      instr_q      <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      miso_sh_q    <= miso_sh_d;
      addr_cnt_q   <= addr_cnt_d;
      write_addr_q <= write_addr_d;
      instr_q      <= instr_d;
      count_q      <= count_d;
      write_en_q   <= write_en_d;
      abort_q      <= abort_d;
    end
  end

  assign spi_miso    = (state_q == StHeader) & miso_sh_q[7];
  assign write_addr  = write_addr_q;
  assign instr_in    = instr_q;
  assign write_en    = write_en_q;
  assign busy        = ~cs_s;
  assign frame_abort = abort_q;
  assign write_count = count_q;

endmodule

// File: tb/tb_spi_instr_loader.sv
// Bench for spi_instr_loader: host-side SPI driver with a write scoreboard checked by a monitor.
module tb_spi_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, write_en, busy, frame_abort;
  logic [4:0]  write_addr;
  logic [15:0] instr_in;
  logic [7:0]  write_count;

  int checks = 0;
  int failures = 0;
  int abort_cnt = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] miso_cap;
  logic       miso_data;

  spi_instr_loader #(
    .ADDR_W(5),
    .INSTR_W(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .write_addr(write_addr),
    .instr_in(instr_in),
    .write_en(write_en),
    .busy(busy),
    .frame_abort(frame_abort),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (write_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr_data", {11'd0, write_addr, instr_in}, 32'hDEAD_0000);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {27'd0, write_addr}, {27'd0, e.a});
        chk("instr_in", {16'd0, instr_in}, {16'd0, e.d});
      end
    end
    if (frame_abort) abort_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic send_bits(input logic [15:0] v, input int n, input bit hdr);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      #60;
      spi_sclk = 1'b1;
      if (hdr) miso_cap = {miso_cap[6:0], spi_miso};
      else miso_data = miso_data | spi_miso;
      #60;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] h, input int nw, input logic [7:0] exp_miso,
                       input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                       input string tag);
    spi_cs_n = 1'b0;
    #60;
    chk({tag, "_busy_high"}, {31'd0, busy}, 32'd1);
    miso_cap = 8'h00;
    send_bits({8'h00, h}, 8, 1'b1);
    chk({tag, "_miso_header"}, {24'd0, miso_cap}, {24'd0, exp_miso});
    miso_data = 1'b0;
    for (int k = 0; k < nw; k++) begin
      case (k)
        0:       send_bits(w0, 16, 1'b0);
        1:       send_bits(w1, 16, 1'b0);
        default: send_bits(w2, 16, 1'b0);
      endcase
    end
    #60;
    spi_cs_n = 1'b1;
    #150;
    chk({tag, "_miso_after_header"}, {31'd0, miso_data}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write_en"}, {31'd0, write_en}, 32'd0);
    chk({tag, "_write_addr"}, {27'd0, write_addr}, 32'd0);
    chk({tag, "_instr_in"}, {16'd0, instr_in}, 32'd0);
    chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_abort"}, {31'd0, frame_abort}, 32'd0);
    chk({tag, "_write_count"}, {24'd0, write_count}, 32'd0);
  endtask

  initial begin
    #33;
    chk_reset_outputs("in_reset");
    #20;
    rst = 1'b1;
    #50;
    chk_reset_outputs("after_release");

    // Single word to address 3.
    exp_q.push_back('{a: 5'd3, d: 16'hA5C3});
    frame(8'h83, 1, 8'h00, 16'hA5C3, 16'h0, 16'h0, "single");
    chk("single_write_count", {24'd0, write_count}, 32'd1);

    // Burst across the address wrap: 30, 31, 0.
    exp_q.push_back('{a: 5'd30, d: 16'h1111});
    exp_q.push_back('{a: 5'd31, d: 16'h2222});
    exp_q.push_back('{a: 5'd0, d: 16'h3333});
    frame(8'h9E, 3, 8'h01, 16'h1111, 16'h2222, 16'h3333, "burst");
    chk("burst_write_count", {24'd0, write_count}, 32'd4);

    // Read header: data ignored, no write, no abort.
    frame(8'h05, 1, 8'h04, 16'hFFFF, 16'h0, 16'h0, "ignore");
    chk("ignore_write_count", {24'd0, write_count}, 32'd4);
    chk("ignore_no_abort", abort_cnt, 32'd0);

    // Partial word then cs_n rise.
    spi_cs_n = 1'b0;
    #60;
    send_bits(16'h0081, 8, 1'b1);
    send_bits(16'h01FF, 9, 1'b0);
    #60;
    spi_cs_n = 1'b1;
    #150;
    chk("abort_pulse_count", abort_cnt, 32'd1);
    chk("abort_write_count", {24'd0, write_count}, 32'd4);

    exp_q.push_back('{a: 5'd1, d: 16'hBEEF});
    frame(8'h81, 1, 8'h04, 16'hBEEF, 16'h0, 16'h0, "post_abort");
    chk("post_abort_write_count", {24'd0, write_count}, 32'd5);
    chk("post_abort_abort_count", abort_cnt, 32'd1);

    // Reset in the middle of a data word.
    spi_cs_n = 1'b0;
    #60;
    send_bits(16'h0082, 8, 1'b1);
    send_bits(16'h007F, 7, 1'b0);
    #30;
    rst = 1'b0;
    #20;
    chk_reset_outputs("mid_reset");
    #20;
    spi_cs_n = 1'b1;
    #30;
    rst = 1'b1;
    #150;
    chk("mid_reset_abort_count", abort_cnt, 32'd1);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);

    exp_q.push_back('{a: 5'd4, d: 16'h1234});
    frame(8'h84, 1, 8'h00, 16'h1234, 16'h0, 16'h0, "after_reset_a");
    chk("after_reset_a_count", {24'd0, write_count}, 32'd1);
    exp_q.push_back('{a: 5'd5, d: 16'h5678});
    frame(8'h85, 1, 8'h01, 16'h5678, 16'h0, 16'h0, "after_reset_b");
    chk("after_reset_b_count", {24'd0, write_count}, 32'd2);

    // Header-only frame: miso must shift out 0x02.
    frame(8'h06, 0, 8'h02, 16'h0, 16'h0, 16'h0, "miso_two");
    chk("miso_two_count", {24'd0, write_count}, 32'd2);
    chk("final_abort_count", abort_cnt, 32'd1);

    #200;
    chk("final_pending_writes", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
